// File: rtl/dot_pkg.sv
// Shared dot geometry and FSM state type for the dot collector and the dot array.
// Both stages import this package so they agree on dot positions.
package dot_pkg;

    localparam int unsigned NUM_DOTS = 10;

    typedef logic [9:0] coord_t;

    localparam coord_t DOT_X [NUM_DOTS] = '{
        10'd39, 10'd221, 10'd601, 10'd222, 10'd542,
        10'd424, 10'd151, 10'd41, 10'd387, 10'd489
    };

    localparam coord_t DOT_Y [NUM_DOTS] = '{
        10'd158, 10'd207, 10'd162, 10'd455, 10'd392,
        10'd349, 10'd302, 10'd28, 10'd115, 10'd210
    };

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StSettle,
        StCheck
    } state_t;

    // Absolute distance widened to 11 bits so the subtraction never wraps.
    function automatic logic [10:0] abs_diff(input coord_t a, input coord_t b);
        logic [10:0] wa;
        logic [10:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa >= wb) ? (wa - wb) : (wb - wa);
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_DOTS-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_DOTS; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dot_collector_if.sv
// Bus between the frame/player driver (master) and the dot collector (slave).
interface dot_collector_if;
    import dot_pkg::*;

    logic                frame_start;
    logic                restart;
    logic [9:0]          PlayerX;
    logic [9:0]          PlayerY;
    logic [NUM_DOTS-1:0] alive_10;
    logic [NUM_DOTS-1:0] kill_10;
    logic [15:0]         score;
    logic [3:0]          dots_left;
    logic                level_clear;
    logic                scan_busy;

    modport master (
        output frame_start, restart, PlayerX, PlayerY, alive_10,
        input  kill_10, score, dots_left, level_clear, scan_busy
    );

    modport slave (
        input  frame_start, restart, PlayerX, PlayerY, alive_10,
        output kill_10, score, dots_left, level_clear, scan_busy
    );

endinterface

// File: rtl/score_counter.sv
// Saturating 16-bit score accumulator with synchronous clear and add-enable.
module score_counter #(
    parameter int unsigned POINTS = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        i_clear,
    input  logic        i_add,
    output logic [15:0] o_score
);

    logic [15:0] r_score;
    logic [16:0] w_sum;
    logic [15:0] w_next;

    always_comb begin
        w_sum  = {1'b0, r_score} + 17'(POINTS);
        w_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n || i_clear) begin
            r_score <= '0;
        end else if (i_add) begin
            r_score <= w_next;
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/dot_collector.sv
// Per-frame dot scanner: one dot per cycle against the player, kill pulses on hits,
// score keeping, remaining-dot count and sticky level-clear flag.
module dot_collector
    import dot_pkg::*;
#(
    parameter int unsigned HIT_RADIUS = 6,
    parameter int unsigned POINTS     = 10
) (
    input  logic          Clk,
    input  logic          Reset_n,
    dot_collector_if.slave bus
);

    localparam logic [3:0]  LAST_IDX = 4'(NUM_DOTS - 1);
    localparam logic [10:0] RADIUS   = 11'(HIT_RADIUS);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_idx;
    logic [3:0]          w_idx_next;
    logic [NUM_DOTS-1:0] r_kill;
    logic [NUM_DOTS-1:0] w_kill_next;
    logic [3:0]          r_dots_left;
    logic                r_level_clear;
    logic [10:0]         w_dx;
    logic [10:0]         w_dy;
    logic                w_hit;
    logic [3:0]          w_pop;

    always_comb begin
        w_dx  = abs_diff(bus.PlayerX, DOT_X[r_idx]);
        w_dy  = abs_diff(bus.PlayerY, DOT_Y[r_idx]);
        w_hit = (r_state == StScan) && bus.alive_10[r_idx] &&
                (w_dx <= RADIUS) && (w_dy <= RADIUS);
        w_pop = popcount(bus.alive_10);
    end

    always_comb begin
        w_kill_next = '0;
        if (w_hit) begin
            w_kill_next[r_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        unique case (r_state)
            StIdle: begin
                if (bus.frame_start && !r_level_clear) begin
                    w_state_next = StScan;
                    w_idx_next   = '0;
                end
            end
            StScan: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = StSettle;
                end else begin
                    w_idx_next = r_idx + 4'd1;
                end
            end
            StSettle: w_state_next = StCheck;
            StCheck:  w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Restart behaves like reset here; the dot array restores its own alive flags.
    always_ff @(posedge Clk) begin
        if (!Reset_n || bus.restart) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_kill        <= '0;
            r_dots_left   <= 4'(NUM_DOTS);
            r_level_clear <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_kill  <= w_kill_next;
            if (r_state == StCheck) begin
                r_dots_left   <= w_pop;
                r_level_clear <= r_level_clear | (w_pop == 4'd0);
            end
        end
    end

    score_counter #(
        .POINTS (POINTS)
    ) u_score (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_clear (bus.restart),
        .i_add   (w_hit),
        .o_score (bus.score)
    );

    assign bus.kill_10     = r_kill;
    assign bus.dots_left   = r_dots_left;
    assign bus.level_clear = r_level_clear;
    assign bus.scan_busy   = (r_state != StIdle);

endmodule

// File: doc/dot_collector.md
Name: dot_collector

Overview:
Upstream of the dot array. Once per video frame it scans every dot against the player position and issues one-cycle kill pulses for dots the player overlaps. It also keeps the score and remaining-dot count, and flags level clear. Dot coordinates come from a shared package, so both stages agree on positions.

Parameters:
NUM_DOTS, 10, number of dots scanned; must equal the dot array width.
HIT_RADIUS, 6, max per-axis pixel distance counted as a hit.
POINTS, 10, score added per dot eaten.

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous reset, active-low
frame_start  in  1  one-cycle pulse per frame (vsync edge)
restart  in  1  one-cycle pulse; clears score and level state
PlayerX  in  10  player centre X, pixels
PlayerY  in  10  player centre Y, pixels
alive_10  in  NUM_DOTS  per-dot alive flags from the dot array
kill_10  out  NUM_DOTS  one-cycle kill pulses to the dot array
score  out  16  accumulated score, binary
dots_left  out  4  popcount of alive_10 at last scan end
level_clear  out  1  sticky; set when no dots remain
scan_busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (Reset_n=0 at a Clk edge) sets: state IDLE, kill_10=0, score=0, dots_left=NUM_DOTS, level_clear=0, scan_busy=0.
- FSM states and transitions:
  - IDLE -> SCAN on frame_start when level_clear=0; idx<=0.
  - SCAN: one dot per cycle. Compares entry idx; idx==NUM_DOTS-1 -> SETTLE, else idx+1.
  - SETTLE: one cycle, lets the dot array apply the last kill. Then -> CHECK.
  - CHECK: dots_left<=popcount(alive_10); level_clear<=1 if popcount==0. Then -> IDLE.
- Hit test:
  - dx=|PlayerX-DotX[idx]| and dy=|PlayerY-DotY[idx]|, computed in 11 bits with no wrap.
  - hit = alive_10[idx] && dx<=HIT_RADIUS && dy<=HIT_RADIUS. Equality counts as a hit.
- Kill timing:
  - A hit in SCAN cycle k registers kill_10=one-hot(idx) in cycle k+1. kill_10 is all zero otherwise, and never has more than one bit set.
  - Score increments in the same cycle as the kill pulse and saturates at 16'hFFFF.
- Latency: with frame_start at cycle 0, SCAN runs cycles 1..NUM_DOTS, kills appear in cycles 2..NUM_DOTS+1, and the FSM is back in IDLE at cycle NUM_DOTS+3 with dots_left updated.
- PlayerX/Y are sampled live each SCAN cycle. The driver holds them stable during scan_busy.
- frame_start while scan_busy=1 is ignored; it is not queued.
- frame_start while level_clear=1 is ignored.
- restart has priority over frame_start and over any state. Next cycle: IDLE, kill_10=0, score=0, level_clear=0, dots_left=NUM_DOTS. Restoring alive flags belongs to the dot array.
- Reset or restart mid-scan aborts the scan. Any kill pulse already registered in that cycle is cleared.
- A dead dot (alive_10[idx]=0) never produces a kill, even when in range.

Decomposition:
- Package dot_pkg holds:
  - NUM_DOTS.
  - Constant arrays DOT_X and DOT_Y, index 0..9.
    - X: 39,221,601,222,542,424,151,41,387,489
    - Y: 158,207,162,455,392,349,302,28,115,210
  - Typedef of the FSM state enum.
- The dot array imports dot_pkg for the same coordinates.
- Sub-module score_counter: saturating 16-bit accumulator with clear and add-enable inputs.

Test Plan:
- Reset_n=0 for 2 cycles -> kill_10=0, score=0, dots_left=10, level_clear=0, scan_busy=0.
- Player (39,158), alive_10=all ones, frame_start at cycle 0 -> kill_10=0000000001 exactly in cycle 2, score=10, then IDLE at cycle 13 with dots_left=9 (dot array clears bit 0).
- Player (45,164), dx=dy=6 -> hit on dot 0. Player (46,158) -> no kill, score unchanged.
- Player (601,162), alive_10[2]=0 -> no kill for the full scan, score unchanged.
- alive_10=0000000100, player at (601,162) -> kill_10[2] in cycle 4. CHECK sees 0, so dots_left=0 and level_clear=1. A further frame_start leaves scan_busy=0.
- restart asserted in cycle 5 of a scan, and separately score preset near 16'hFFFF -> abort to IDLE with score=0. Saturation check: 16'hFFFA plus a hit gives 16'hFFFF, not a wrap.
